ysyx_24070016_wbu: RTL and testbench
====================================

YSYX_24070016_WBU -- requirements
Module: ysyx_24070016_WBU

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 5, register address width; DATA_WIDTH, default 32, data width; NREG, default 16, number of implemented registers.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port exu_valid, input, 1, execute result offered.
REQ-005 SHALL have port exu_ready, output, 1, WBU accepts the execute result.
REQ-006 SHALL have port exu_wen, input, 1, instruction writes rd.
REQ-007 SHALL have port exu_is_load, input, 1, rd data will come from the load response.
REQ-008 SHALL have port exu_rd, input, ADDR_WIDTH, destination register.
REQ-009 SHALL have port exu_data, input, DATA_WIDTH, execute result.
REQ-010 SHALL have port lsu_valid, input, 1, load data valid (single-cycle pulse, no ready).
REQ-011 SHALL have port lsu_data, input, DATA_WIDTH, load data.
REQ-012 SHALL have ports rf_wen (output, 1), rf_waddr (output, ADDR_WIDTH) and rf_wdata (output, DATA_WIDTH), the register-file write port, all registered.
REQ-013 SHALL have ports chk_addr1 and chk_addr2 (input, ADDR_WIDTH each), and chk_busy1 and chk_busy2 (output, 1 each), for hazard query.
REQ-014 SHALL have port retired, output, 32, count of completed instructions.
REQ-015 SHALL have port err, output, 1, sticky flag for an unexpected load response.

Function
REQ-016 SHALL implement FSM with states IDLE and WAIT_LOAD; exu_ready = 1 only in IDLE.
REQ-017 Handshake SHALL be accepted on a cycle with exu_valid & exu_ready.
REQ-018 Accepted non-load with exu_wen=1 and 0 < exu_rd < NREG: the next cycle SHALL have rf_wen=1, rf_waddr=exu_rd and rf_wdata=exu_data (1-cycle latency).
REQ-019 Accepted non-load with exu_wen=0, exu_rd=0 or exu_rd>=NREG: rf_wen SHALL stay 0 next cycle; the instruction still retires.
REQ-020 Accepted load: the FSM SHALL enter WAIT_LOAD and latch rd; if 0 < rd < NREG, busy[rd] SHALL be set.
REQ-021 In WAIT_LOAD, on lsu_valid=1: the next cycle SHALL have rf_wen=1 with latched rd and lsu_data (suppressed if rd is 0 or >= NREG); busy[rd] SHALL be cleared; the FSM SHALL return to IDLE.
REQ-022 In WAIT_LOAD without lsu_valid, the FSM SHALL hold indefinitely, with no timeout.
REQ-023 lsu_valid in IDLE SHALL be ignored for writes and SHALL set err, which stays set until reset.
REQ-024 rf_wen SHALL be a one-cycle pulse per write; no back-to-back conflict exists because WAIT_LOAD blocks exu.
REQ-025 chk_busyN SHALL be combinational: busy[chk_addrN] OR (rf_wen & rf_waddr==chk_addrN).
REQ-026 chk_busyN SHALL be 0 for chk_addrN == 0 or chk_addrN >= NREG.
REQ-027 retired SHALL increment by 1 when a non-load is accepted and when a load response is consumed.
REQ-028 retired SHALL wrap from 0xFFFFFFFF to 0.
REQ-029 The FSM SHALL be able to accept a new exu handshake in the cycle after the load-writeback cycle in which it returns to IDLE.

Reset
REQ-030 While rst=1, and at any time including mid-WAIT_LOAD, the block SHALL set: FSM=IDLE, busy=0, rf_wen=0, rf_waddr=0, rf_wdata=0, retired=0, err=0; exu_ready SHALL be 1 once the FSM is in IDLE.
REQ-031 An lsu_valid arriving after a reset that aborted a load SHALL set err.

Verification
REQ-032 ALU write: exu_valid=1, exu_wen=1, exu_rd=5, exu_data=0xDEADBEEF -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF; retired=1.
REQ-033 Load: accept load with rd=3; chk_addr1=3 -> chk_busy1=1 and exu_ready=0 for 10 cycles; lsu_valid with 0x1234 -> rf_wen=1, waddr=3, wdata=0x1234 next cycle; busy clears; exu_ready=1.
REQ-034 Suppression: writes to rd=0 and rd=20 -> rf_wen stays 0, retired increments by 2, chk_busy for 0 and 20 stays 0.
REQ-035 Stray response: lsu_valid=1 in IDLE -> err=1, rf_wen=0; err holds until rst.
REQ-036 Reset mid-load: rd=7 load pending, assert rst asynchronously -> busy[7]=0 and state IDLE immediately; a later lsu_valid -> err=1, no write.

Source files
------------

// File: rtl/ysyx_24070016_wbu.sv
// Write-back unit: retires execute results, waits for load data, drives the
// register-file write port and answers scoreboard (busy) queries for hazards.
module ysyx_24070016_wbu #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NREG       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic                  exu_wen,
    input  logic                  exu_is_load,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [ADDR_WIDTH-1:0] chk_addr1,
    input  logic [ADDR_WIDTH-1:0] chk_addr2,
    output logic                  chk_busy1,
    output logic                  chk_busy2,
    output logic [31:0]           retired,
    output logic                  err
);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] WAIT_LOAD = 1'b1;

    // True for a writable destination: nonzero and below NREG.
    function automatic logic rd_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a != {ADDR_WIDTH{1'b0}}) && (32'(a) < 32'(NREG));
    endfunction

    function automatic logic [NREG-1:0] decode(input logic [ADDR_WIDTH-1:0] a);
        logic [NREG-1:0] oh;
        oh = {NREG{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            oh[i] = (a == ADDR_WIDTH'(i));
        end
        return oh;
    endfunction

    function automatic logic busy_lookup(input logic [NREG-1:0] vec,
                                         input logic [ADDR_WIDTH-1:0] a);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            hit = hit | (vec[i] & (a == ADDR_WIDTH'(i)));
        end
        return hit;
    endfunction

    logic [0:0]            state_r, state_s;
    logic [NREG-1:0]       busy_r, busy_s;
    logic [ADDR_WIDTH-1:0] load_rd_r, load_rd_s;
    logic                  rf_wen_r, rf_wen_s;
    logic [ADDR_WIDTH-1:0] rf_waddr_r, rf_waddr_s;
    logic [DATA_WIDTH-1:0] rf_wdata_r, rf_wdata_s;
    logic [31:0]           retired_r, retired_s;
    logic                  err_r, err_s;
    logic                  accept_s;

    assign exu_ready = (state_r == IDLE);
    assign accept_s  = exu_valid & exu_ready;

    // Next-state logic for the FSM, scoreboard, write port and counters.
    always_comb begin
        state_s    = state_r;
        busy_s     = busy_r;
        load_rd_s  = load_rd_r;
        rf_wen_s   = 1'b0;
        rf_waddr_s = rf_waddr_r;
        rf_wdata_s = rf_wdata_r;
        retired_s  = retired_r;
        err_s      = err_r;
        case (state_r)
            IDLE: begin
                if (lsu_valid) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
                if (accept_s && exu_is_load) begin
                    state_s   = WAIT_LOAD;
                    load_rd_s = exu_rd;
                    if (rd_ok(exu_rd)) begin
                        busy_s = busy_r | decode(exu_rd);
                    end else begin
                        busy_s = busy_r;
                    end
                end else if (accept_s) begin
                    retired_s = retired_r + 32'd1;
                    if (exu_wen && rd_ok(exu_rd)) begin
                        rf_wen_s   = 1'b1;
                        rf_waddr_s = exu_rd;
                        rf_wdata_s = exu_data;
                    end else begin
                        rf_wen_s = 1'b0;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_LOAD: begin
                // No timeout: the load response is the only way out, besides reset.
                if (lsu_valid) begin
                    state_s   = IDLE;
                    busy_s    = busy_r & ~decode(load_rd_r);
                    retired_s = retired_r + 32'd1;
                    if (rd_ok(load_rd_r)) begin
                        rf_wen_s   = 1'b1;
                        rf_waddr_s = load_rd_r;
                        rf_wdata_s = lsu_data;
                    end else begin
                        rf_wen_s = 1'b0;
                    end
                end else begin
                    state_s = WAIT_LOAD;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = {NREG{1'b0}};
            end
        endcase
    end

    // State registers; reset aborts any pending load and clears the scoreboard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            busy_r     <= {NREG{1'b0}};
            load_rd_r  <= {ADDR_WIDTH{1'b0}};
            rf_wen_r   <= 1'b0;
            rf_waddr_r <= {ADDR_WIDTH{1'b0}};
            rf_wdata_r <= {DATA_WIDTH{1'b0}};
            retired_r  <= 32'd0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            busy_r     <= busy_s;
            load_rd_r  <= load_rd_s;
            rf_wen_r   <= rf_wen_s;
            rf_waddr_r <= rf_waddr_s;
            rf_wdata_r <= rf_wdata_s;
            retired_r  <= retired_s;
            err_r      <= err_s;
        end
    end

    assign rf_wen   = rf_wen_r;
    assign rf_waddr = rf_waddr_r;
    assign rf_wdata = rf_wdata_r;
    assign retired  = retired_r;
    assign err      = err_r;

    // A register is also busy while its write is still on the write port.
    assign chk_busy1 = rd_ok(chk_addr1) &
                       (busy_lookup(busy_r, chk_addr1) | (rf_wen_r & (rf_waddr_r == chk_addr1)));
    assign chk_busy2 = rd_ok(chk_addr2) &
                       (busy_lookup(busy_r, chk_addr2) | (rf_wen_r & (rf_waddr_r == chk_addr2)));

endmodule

// File: tb/tb_ysyx_24070016_wbu.sv
// Directed bench for the write-back unit: ALU writes, loads, suppression,
// stray load responses and reset in the middle of a pending load.
module tb_ysyx_24070016_wbu;

    logic        clk;
    logic        rst;
    logic        exu_valid;
    logic        exu_ready;
    logic        exu_wen;
    logic        exu_is_load;
    logic [4:0]  exu_rd;
    logic [31:0] exu_data;
    logic        lsu_valid;
    logic [31:0] lsu_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        chk_busy1;
    logic        chk_busy2;
    logic [31:0] retired;
    logic        err;

    int n_checks;
    int n_fail;

    ysyx_24070016_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NREG(16)) dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_wen(exu_wen),
        .exu_is_load(exu_is_load), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_data(lsu_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .retired(retired), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic ld, input logic wen, input logic [4:0] rd, input logic [31:0] d);
        exu_valid   = 1'b1;
        exu_is_load = ld;
        exu_wen     = wen;
        exu_rd      = rd;
        exu_data    = d;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        exu_valid = 1'b0; exu_wen = 1'b0; exu_is_load = 1'b0;
        exu_rd = 5'd0; exu_data = 32'd0;
        lsu_valid = 1'b0; lsu_data = 32'd0;
        chk_addr1 = 5'd5; chk_addr2 = 5'd0;
        step();
        step();
        check_val("rst_rf_wen",   32'(rf_wen),    32'd0);
        check_val("rst_waddr",    32'(rf_waddr),  32'd0);
        check_val("rst_wdata",    rf_wdata,       32'd0);
        check_val("rst_retired",  retired,        32'd0);
        check_val("rst_err",      32'(err),       32'd0);
        check_val("rst_ready",    32'(exu_ready), 32'd1);
        rst = 1'b0;
        step();
        check_val("idle_busy5", 32'(chk_busy1), 32'd0);

        // ALU write to x5
        offer(1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
        step();
        exu_valid = 1'b0;
        check_val("alu_wen",     32'(rf_wen),    32'd1);
        check_val("alu_waddr",   32'(rf_waddr),  32'd5);
        check_val("alu_wdata",   rf_wdata,       32'hDEADBEEF);
        check_val("alu_retired", retired,        32'd1);
        check_val("alu_fwd_busy", 32'(chk_busy1), 32'd1);
        step();
        check_val("alu_pulse",   32'(rf_wen),    32'd0);
        check_val("alu_busy_clr", 32'(chk_busy1), 32'd0);

        // Load to x3, held for 10 cycles while a competing ALU op is offered
        chk_addr1 = 5'd3;
        chk_addr2 = 5'd9;
        offer(1'b1, 1'b1, 5'd3, 32'h0);
        step();
        offer(1'b0, 1'b1, 5'd9, 32'h0000A5A5);
        for (int i = 0; i < 10; i++) begin
            check_val("ld_busy",  32'(chk_busy1), 32'd1);
            check_val("ld_ready", 32'(exu_ready), 32'd0);
            check_val("ld_nowen", 32'(rf_wen),    32'd0);
            step();
        end
        check_val("ld_hold_retired", retired, 32'd1);
        lsu_valid = 1'b1;
        lsu_data  = 32'h00001234;
        step();
        lsu_valid = 1'b0;
        check_val("ld_wen",      32'(rf_wen),    32'd1);
        check_val("ld_waddr",    32'(rf_waddr),  32'd3);
        check_val("ld_wdata",    rf_wdata,       32'h00001234);
        check_val("ld_retired",  retired,        32'd2);
        check_val("ld_ready_back", 32'(exu_ready), 32'd1);
        check_val("ld_fwd_busy", 32'(chk_busy1), 32'd1);
        // the pending ALU op to x9 is accepted in this same cycle
        step();
        exu_valid = 1'b0;
        check_val("post_ld_busy3", 32'(chk_busy1), 32'd0);
        check_val("b2b_wen",     32'(rf_wen),    32'd1);
        check_val("b2b_waddr",   32'(rf_waddr),  32'd9);
        check_val("b2b_wdata",   rf_wdata,       32'h0000A5A5);
        check_val("b2b_retired", retired,        32'd3);
        check_val("b2b_busy9",   32'(chk_busy2), 32'd1);

        // Suppressed writes: rd=0, rd=20, wen=0, and a load to rd=20
        chk_addr1 = 5'd0;
        chk_addr2 = 5'd20;
        offer(1'b0, 1'b1, 5'd0, 32'h1);
        step();
        check_val("sup0_wen",  32'(rf_wen),    32'd0);
        check_val("sup0_busy", 32'(chk_busy1), 32'd0);
        offer(1'b0, 1'b1, 5'd20, 32'h2);
        step();
        check_val("sup20_wen",  32'(rf_wen),    32'd0);
        check_val("sup20_busy", 32'(chk_busy2), 32'd0);
        check_val("sup_retired", retired,       32'd5);
        offer(1'b0, 1'b0, 5'd6, 32'h3);
        step();
        check_val("nowen_wen",     32'(rf_wen), 32'd0);
        check_val("nowen_retired", retired,     32'd6);
        offer(1'b1, 1'b1, 5'd20, 32'h0);
        step();
        exu_valid = 1'b0;
        check_val("ld20_ready", 32'(exu_ready), 32'd0);
        check_val("ld20_busy",  32'(chk_busy2), 32'd0);
        lsu_valid = 1'b1;
        lsu_data  = 32'h55;
        step();
        lsu_valid = 1'b0;
        check_val("ld20_wen",     32'(rf_wen),    32'd0);
        check_val("ld20_retired", retired,        32'd7);
        check_val("ld20_ready2",  32'(exu_ready), 32'd1);
        check_val("ld20_err",     32'(err),       32'd0);

        // Boundary registers 15 (last implemented) and 16 (first unimplemented)
        chk_addr1 = 5'd15;
        chk_addr2 = 5'd16;
        offer(1'b0, 1'b1, 5'd15, 32'hCAFE0015);
        step();
        check_val("r15_wen",   32'(rf_wen),    32'd1);
        check_val("r15_waddr", 32'(rf_waddr),  32'd15);
        check_val("r15_busy",  32'(chk_busy1), 32'd1);
        offer(1'b0, 1'b1, 5'd16, 32'hCAFE0016);
        step();
        exu_valid = 1'b0;
        check_val("r16_wen",     32'(rf_wen),    32'd0);
        check_val("r16_busy",    32'(chk_busy2), 32'd0);
        check_val("r16_retired", retired,        32'd9);

        // Stray load response in IDLE
        lsu_valid = 1'b1;
        lsu_data  = 32'hBAD0BAD0;
        step();
        lsu_valid = 1'b0;
        check_val("stray_err",     32'(err),    32'd1);
        check_val("stray_wen",     32'(rf_wen), 32'd0);
        check_val("stray_retired", retired,     32'd9);
        step();
        step();
        check_val("stray_err_hold", 32'(err), 32'd1);

        // Asynchronous reset while a load to x7 is pending
        chk_addr1 = 5'd7;
        offer(1'b1, 1'b1, 5'd7, 32'h0);
        step();
        exu_valid = 1'b0;
        check_val("ld7_busy",  32'(chk_busy1), 32'd1);
        check_val("ld7_ready", 32'(exu_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_busy7",   32'(chk_busy1), 32'd0);
        check_val("arst_ready",   32'(exu_ready), 32'd1);
        check_val("arst_err",     32'(err),       32'd0);
        check_val("arst_retired", retired,        32'd0);
        step();
        rst = 1'b0;
        lsu_valid = 1'b1;
        lsu_data  = 32'h77777777;
        step();
        lsu_valid = 1'b0;
        check_val("late_lsu_err",     32'(err),    32'd1);
        check_val("late_lsu_wen",     32'(rf_wen), 32'd0);
        check_val("late_lsu_retired", retired,     32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
